pipeline_datapath: RTL and testbench
====================================

PIPELINE_DATAPATH -- requirements
Module: pipeline_datapath

Interface
REQ-001 SHALL have parameter DW, default 32, data/ALU/register/memory word width (>=16).
REQ-002 SHALL have parameter NREG, default 32, register count; RA=clog2(NREG) address bits taken from instr rs/rt/rd low bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, data-memory words; MA=clog2(MEM_DEPTH).
REQ-004 SHALL have ports: clk  in  1  rising-edge clock, the only clock.
REQ-005 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: instr_valid  in  1  instr/control valid this cycle; 0 = bubble.
REQ-007 SHALL have ports: instr  in  32  ID-stage instruction (rs[25:21], rt[20:16], rd[15:11], imm[15:0], funct[5:0]).
REQ-008 SHALL have ports: wb_id  in  2  {RegWrite, MemtoReg}.
REQ-009 SHALL have ports: me_id  in  3  {Branch, MemRead, MemWrite}.
REQ-010 SHALL have ports: ex_id  in  4  {RegDst, ALUOp[1:0], ALUSrc}.
REQ-011 SHALL have ports: stall  out  1  load-use hazard; upstream holds instr/controls.
REQ-012 SHALL have ports: branch  out  1  MEM-stage Branch AND registered zero.
REQ-013 SHALL have ports: wb_en, wb_addr, wb_data  out  1/RA/DW  WB-stage write observation.

Function
REQ-014 SHALL implement stages ID, EX, MEM, WB with ID/EX, EX/MEM, MEM/WB registers; instruction accepted in cycle N writes its register at the clk edge ending cycle N+3.
REQ-015 SHALL hold NREG x DW register file; register 0 reads 0, writes to it ignored.
REQ-016 SHALL bypass inside the register file: WB write to register r in the same cycle as ID read of r returns the write data.
REQ-017 SHALL sign-extend imm[15:0] to DW in ID.
REQ-018 SHALL latch funct[5:0] into ID/EX; ALU control uses EX-stage funct only.
REQ-019 SHALL decode ALUOp: 00 add, 01 sub, 10 by funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt -> 1/0); unlisted funct or ALUOp 11 -> add.
REQ-020 SHALL use ALUSrc=1 immediate, else forwarded rt as ALU operand B; add/sub wrap modulo 2^DW; zero = (result==0).
REQ-021 SHALL select destination rd when RegDst=1, rt when RegDst=0.
REQ-022 SHALL forward each EX operand: EX/MEM ALU result if EX/MEM RegWrite, dest!=0, dest==src; else MEM/WB write data under same rule; else ID/EX value; EX/MEM has priority.
REQ-023 SHALL use forwarded rt as store data.
REQ-024 SHALL word-address memory with ALU result[MA-1:0] (higher bits ignored, wrap); write synchronous in MEM when MemWrite; read combinational in MEM, full DW.
REQ-025 SHALL write back memory data when MemtoReg=1, ALU result when 0.
REQ-026 SHALL assert stall combinationally when ID/EX MemRead=1, ID/EX rt!=0, and rt equals ID rs or ID rt; ID/EX then loads a bubble (all controls 0); the held instruction enters EX next cycle.
REQ-027 SHALL treat instr_valid=0 as bubble: ID/EX controls 0, no register/memory writes.
REQ-028 SHALL register branch = EX/MEM Branch AND EX/MEM zero; no flush performed internally.
REQ-029 SHALL drive wb_en=MEM/WB RegWrite AND dest!=0, wb_addr=dest, wb_data=write-back data.

Reset
REQ-030 SHALL on rst_n=0 immediately clear all pipeline registers (controls 0), all registers to 0, stall/branch/wb_en/wb_addr/wb_data to 0; memory contents not reset.
REQ-031 SHALL discard in-flight instructions on reset mid-operation; no write occurs at or after reset assertion until new instructions arrive after release.

Verification
REQ-032 SHALL cover: addi r1=r0+5, next cycle add r2=r1+r1 (ALUOp 10, funct 0x20) -> EX/MEM forward, r2=10 written cycle N+4.
REQ-033 SHALL cover: sw r2->mem[3], lw r3<-mem[3], add r4=r3+r3 -> stall=1 one cycle, then r4=20; wb_en pattern shows one bubble.
REQ-034 SHALL cover: slt r5=r6<r7 with r6=-1, r7=1 -> r5=1; swapped -> 0; sub 0-1 -> all-ones (wrap).
REQ-035 SHALL cover: any write targeting r0 -> wb_en=0, r0 reads 0; ID read of register written same cycle returns new value.
REQ-036 SHALL cover: beq-style Branch with equal operands -> branch=1 exactly in cycle N+2; unequal -> 0.
REQ-037 SHALL cover: rst_n low while three instructions in flight -> outputs 0 asynchronously, registers 0, no writes after release until new valid instr; repeat with DW=16, NREG=8, MEM_DEPTH=16 including address wrap (addr 17 -> word 1).

Source files
------------

// File: rtl/pipeline_datapath.sv
// Four-stage (ID/EX/MEM/WB) integer datapath with a bypassing register file,
// EX-stage operand forwarding, load-use stall detection and a word-addressed
// data memory. Control words arrive already decoded alongside the instruction.
module pipeline_datapath #(
    parameter int DW        = 32,
    parameter int NREG      = 32,
    parameter int MEM_DEPTH = 256,
    localparam int RA = $clog2(NREG),
    localparam int MA = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [31:0]   instr,
    input  logic [1:0]    wb_id,
    input  logic [2:0]    me_id,
    input  logic [3:0]    ex_id,
    output logic          stall,
    output logic          branch,
    output logic          wb_en,
    output logic [RA-1:0] wb_addr,
    output logic [DW-1:0] wb_data
);

    // ID stage fields
    logic [RA-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_val, id_rt_val, id_imm;
    logic          id_bubble;

    // ID/EX register: controls {RegWrite,MemtoReg}, {Branch,MemRead,MemWrite}, {RegDst,ALUOp,ALUSrc}
    logic [1:0]    idex_wb;
    logic [2:0]    idex_me;
    logic [3:0]    idex_ex;
    logic [DW-1:0] idex_rs_val, idex_rt_val, idex_imm;
    logic [RA-1:0] idex_rs, idex_rt, idex_rd;
    logic [5:0]    idex_funct;

    // EX stage
    logic [DW-1:0] fwd_a, fwd_b, alu_b, alu_y;
    logic [RA-1:0] ex_dest;

    // EX/MEM register
    logic [1:0]    exmem_wb;
    logic          exmem_branch, exmem_memwrite, exmem_zero;
    logic [DW-1:0] exmem_alu, exmem_store;
    logic [RA-1:0] exmem_dest;

    // MEM stage
    logic [DW-1:0] mem [MEM_DEPTH];
    logic [DW-1:0] mem_rdata;

    // MEM/WB register
    logic [1:0]    memwb_wb;
    logic [DW-1:0] memwb_alu, memwb_mem;
    logic [RA-1:0] memwb_dest;

    // Register file
    logic [DW-1:0] regs [NREG];

    assign id_rs  = instr[21 +: RA];
    assign id_rt  = instr[16 +: RA];
    assign id_rd  = instr[11 +: RA];
    assign id_imm = DW'($signed(instr[15:0]));

    assign stall     = idex_me[1] && (idex_rt != '0) && ((idex_rt == id_rs) || (idex_rt == id_rt));
    assign id_bubble = stall || !instr_valid;

    // Register file reads: r0 is hard zero, a same-cycle write-back is bypassed to the reader
    always_comb begin
        id_rs_val = regs[id_rs];
        id_rt_val = regs[id_rt];
        if (id_rs == '0)
            id_rs_val = '0;
        else if (wb_en && (wb_addr == id_rs))
            id_rs_val = wb_data;
        if (id_rt == '0)
            id_rt_val = '0;
        else if (wb_en && (wb_addr == id_rt))
            id_rt_val = wb_data;
    end

    // Register file writes from WB; r0 is never written because wb_en excludes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // ID/EX register: a stall or invalid slot inserts a bubble by zeroing every control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_wb     <= '0;
            idex_me     <= '0;
            idex_ex     <= '0;
            idex_rs_val <= '0;
            idex_rt_val <= '0;
            idex_imm    <= '0;
            idex_rs     <= '0;
            idex_rt     <= '0;
            idex_rd     <= '0;
            idex_funct  <= '0;
        end else begin
            idex_wb     <= id_bubble ? 2'b00 : wb_id;
            idex_me     <= id_bubble ? 3'b000 : me_id;
            idex_ex     <= id_bubble ? 4'b0000 : ex_id;
            idex_rs_val <= id_rs_val;
            idex_rt_val <= id_rt_val;
            idex_imm    <= id_imm;
            idex_rs     <= id_rs;
            idex_rt     <= id_rt;
            idex_rd     <= id_rd;
            idex_funct  <= instr[5:0];
        end
    end

    // Operand forwarding: the younger EX/MEM result wins over the MEM/WB write-back value
    always_comb begin
        fwd_a = idex_rs_val;
        fwd_b = idex_rt_val;
        if (exmem_wb[1] && (exmem_dest != '0) && (exmem_dest == idex_rs))
            fwd_a = exmem_alu;
        else if (wb_en && (memwb_dest == idex_rs))
            fwd_a = wb_data;
        if (exmem_wb[1] && (exmem_dest != '0) && (exmem_dest == idex_rt))
            fwd_b = exmem_alu;
        else if (wb_en && (memwb_dest == idex_rt))
            fwd_b = wb_data;
    end

    // ALU: ALUOp 00 add, 01 sub, 10 decoded from funct, anything unlisted falls back to add
    always_comb begin
        alu_b = idex_ex[0] ? idex_imm : fwd_b;
        alu_y = fwd_a + alu_b;
        case (idex_ex[2:1])
            2'b01: alu_y = fwd_a - alu_b;
            2'b10: begin
                case (idex_funct)
                    6'h22:   alu_y = fwd_a - alu_b;
                    6'h24:   alu_y = fwd_a & alu_b;
                    6'h25:   alu_y = fwd_a | alu_b;
                    6'h2A:   alu_y = ($signed(fwd_a) < $signed(alu_b)) ? DW'(1) : '0;
                    default: alu_y = fwd_a + alu_b;
                endcase
            end
            default: alu_y = fwd_a + alu_b;
        endcase
    end

    assign ex_dest = idex_ex[3] ? idex_rd : idex_rt;

    // EX/MEM register: keeps the result, its zero flag and the forwarded store data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_wb       <= '0;
            exmem_branch   <= 1'b0;
            exmem_memwrite <= 1'b0;
            exmem_zero     <= 1'b0;
            exmem_alu      <= '0;
            exmem_store    <= '0;
            exmem_dest     <= '0;
        end else begin
            exmem_wb       <= idex_wb;
            exmem_branch   <= idex_me[2];
            exmem_memwrite <= idex_me[0];
            exmem_zero     <= (alu_y == '0);
            exmem_alu      <= alu_y;
            exmem_store    <= fwd_b;
            exmem_dest     <= ex_dest;
        end
    end

    assign branch    = exmem_branch && exmem_zero;
    assign mem_rdata = mem[exmem_alu[MA-1:0]];

    // Data memory write port; contents survive reset, address wraps on the low bits
    always_ff @(posedge clk) begin
        if (exmem_memwrite)
            mem[exmem_alu[MA-1:0]] <= exmem_store;
    end

    // MEM/WB register: captures both candidate write-back values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_wb   <= '0;
            memwb_alu  <= '0;
            memwb_mem  <= '0;
            memwb_dest <= '0;
        end else begin
            memwb_wb   <= exmem_wb;
            memwb_alu  <= exmem_alu;
            memwb_mem  <= mem_rdata;
            memwb_dest <= exmem_dest;
        end
    end

    assign wb_en   = memwb_wb[1] && (memwb_dest != '0);
    assign wb_addr = memwb_dest;
    assign wb_data = memwb_wb[0] ? memwb_mem : memwb_alu;

endmodule

// File: tb/tb_pipeline_datapath.sv
// Bench for pipeline_datapath: an architectural (program-order) model predicts
// the write-back, branch and stall outputs cycle by cycle for a 32-bit and a
// 16-bit instance; literal expectations pin key results.
module tb_pipeline_datapath;

    localparam int NCYC = 1024;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [1:0]  wb_id;
    logic [2:0]  me_id;
    logic [3:0]  ex_id;

    logic        stall32, branch32, wb_en32;
    logic [4:0]  wb_addr32;
    logic [31:0] wb_data32;
    logic        stall16, branch16, wb_en16;
    logic [2:0]  wb_addr16;
    logic [15:0] wb_data16;

    pipeline_datapath dut32 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .wb_id(wb_id), .me_id(me_id), .ex_id(ex_id),
        .stall(stall32), .branch(branch32), .wb_en(wb_en32),
        .wb_addr(wb_addr32), .wb_data(wb_data32)
    );

    pipeline_datapath #(.DW(16), .NREG(8), .MEM_DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .wb_id(wb_id), .me_id(me_id), .ex_id(ex_id),
        .stall(stall16), .branch(branch16), .wb_en(wb_en16),
        .wb_addr(wb_addr16), .wb_data(wb_data16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit checking = 0;
    bit use16 = 0;

    // active model configuration
    int dw = 32;
    int ra = 5;
    int mdepth = 256;

    logic [63:0] mregs [32];
    logic [63:0] mmem [256];
    bit          last_load;
    int          last_load_rt;

    bit          exp_stall [NCYC];
    bit          exp_br    [NCYC];
    bit          exp_en    [NCYC];
    logic [7:0]  exp_addr  [NCYC];
    logic [63:0] exp_data  [NCYC];

    bit          lit_wb_on [NCYC];
    bit          lit_wb_en [NCYC];
    logic [7:0]  lit_addr  [NCYC];
    logic [63:0] lit_data  [NCYC];
    bit          lit_br_on [NCYC];
    bit          lit_br    [NCYC];
    bit          lit_st_on [NCYC];
    bit          lit_st    [NCYC];

    logic        act_stall, act_br, act_en;
    logic [7:0]  act_addr;
    logic [63:0] act_data;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    function automatic logic [63:0] model_mask();
        return (64'd1 << dw) - 64'd1;
    endfunction

    function automatic int fld(input logic [31:0] ins, input int lsb);
        return int'((ins >> lsb) & 32'd31) & ((1 << ra) - 1);
    endfunction

    function automatic longint as_signed(input logic [63:0] v);
        if (v[dw-1])
            return longint'(v | ~model_mask());
        return longint'(v);
    endfunction

    function automatic logic [63:0] model_alu(input logic [1:0] op, input logic [5:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        r = a + b;
        if (op == 2'b01)
            r = a - b;
        else if (op == 2'b10) begin
            if (f == 6'h22) r = a - b;
            else if (f == 6'h24) r = a & b;
            else if (f == 6'h25) r = a | b;
            else if (f == 6'h2A) r = (as_signed(a) < as_signed(b)) ? 64'd1 : 64'd0;
        end
        return r & model_mask();
    endfunction

    // Executes one accepted instruction in program order and schedules its visible effects
    task automatic model_execute(input logic [31:0] ins, input logic [1:0] w, input logic [2:0] m, input logic [3:0] e, input int c);
        int rs, rt, rd, dest, addr;
        logic [63:0] a, b, opb, res, val;
        rs = fld(ins, 21);
        rt = fld(ins, 16);
        rd = fld(ins, 11);
        a = mregs[rs];
        b = mregs[rt];
        opb = e[0] ? ({{48{ins[15]}}, ins[15:0]} & model_mask()) : b;
        res = model_alu(e[2:1], ins[5:0], a, opb);
        addr = int'(res % 64'(mdepth));
        if (m[0])
            mmem[addr] = b;
        val = w[0] ? mmem[addr] : res;
        dest = e[3] ? rd : rt;
        if (w[1] && dest != 0) begin
            mregs[dest] = val;
            if (c + 3 < NCYC) begin
                exp_en[c+3] = 1'b1;
                exp_addr[c+3] = 8'(dest);
                exp_data[c+3] = val;
            end
        end
        if (c + 2 < NCYC)
            exp_br[c+2] = m[2] && (res == 64'd0);
    endtask

    // Drives one slot, repeating it while the model predicts a load-use stall
    task automatic apply_stimulus(input bit v, input logic [31:0] ins, input logic [1:0] w, input logic [2:0] m, input logic [3:0] e, output int acc);
        bit done;
        bit st;
        int rt;
        done = 0;
        acc = -1;
        for (int k = 0; k < 4 && !done; k++) begin
            instr_valid = v;
            instr = ins;
            wb_id = w;
            me_id = m;
            ex_id = e;
            rt = fld(ins, 16);
            st = last_load && (last_load_rt != 0) && (last_load_rt == fld(ins, 21) || last_load_rt == rt);
            if (cyc < NCYC)
                exp_stall[cyc] = st;
            if (v && !st) begin
                model_execute(ins, w, m, e, cyc);
                acc = cyc;
                done = 1;
            end else if (!v) begin
                done = 1;
            end
            last_load = v && !st && m[1];
            last_load_rt = rt;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'b0, f};
    endfunction

    function automatic logic [31:0] i_type(input int rs, input int rt, input logic [15:0] imm);
        return {6'b0, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic alu_r(input int rs, input int rt, input int rd, input logic [5:0] f, output int acc);
        apply_stimulus(1'b1, r_type(rs, rt, rd, f), 2'b10, 3'b000, 4'b1100, acc);
    endtask

    task automatic sub_r(input int rs, input int rt, input int rd, output int acc);
        apply_stimulus(1'b1, r_type(rs, rt, rd, 6'h00), 2'b10, 3'b000, 4'b1010, acc);
    endtask

    task automatic addi(input int rt, input int rs, input logic [15:0] imm, output int acc);
        apply_stimulus(1'b1, i_type(rs, rt, imm), 2'b10, 3'b000, 4'b0001, acc);
    endtask

    task automatic lw(input int rt, input int rs, input logic [15:0] imm, output int acc);
        apply_stimulus(1'b1, i_type(rs, rt, imm), 2'b11, 3'b010, 4'b0001, acc);
    endtask

    task automatic sw(input int rt, input int rs, input logic [15:0] imm, output int acc);
        apply_stimulus(1'b1, i_type(rs, rt, imm), 2'b00, 3'b001, 4'b0001, acc);
    endtask

    task automatic beq(input int rs, input int rt, output int acc);
        apply_stimulus(1'b1, i_type(rs, rt, 16'h0), 2'b00, 3'b100, 4'b0010, acc);
    endtask

    task automatic bubble(input int n);
        int acc;
        for (int k = 0; k < n; k++)
            apply_stimulus(1'b0, 32'h0, 2'b00, 3'b000, 4'b0000, acc);
    endtask

    task automatic lit_wb(input int c, input bit en, input int addr, input logic [63:0] d);
        if (c >= 0 && c < NCYC) begin
            lit_wb_on[c] = 1'b1;
            lit_wb_en[c] = en;
            lit_addr[c] = 8'(addr);
            lit_data[c] = d;
        end
    endtask

    task automatic lit_branch(input int c, input bit v);
        if (c >= 0 && c < NCYC) begin
            lit_br_on[c] = 1'b1;
            lit_br[c] = v;
        end
    endtask

    task automatic lit_stall(input int c, input bit v);
        if (c >= 0 && c < NCYC) begin
            lit_st_on[c] = 1'b1;
            lit_st[c] = v;
        end
    endtask

    // Asserts reset mid-cycle, drops everything in flight, optionally checks outputs clear at once
    task automatic reset_pipeline(input int ncyc, input bit check_async);
        instr_valid = 1'b0;
        instr = 32'h0;
        wb_id = 2'b00;
        me_id = 3'b000;
        ex_id = 4'b0000;
        rst_n = 1'b0;
        for (int k = 0; k < 32; k++)
            mregs[k] = 64'd0;
        last_load = 0;
        last_load_rt = 0;
        for (int k = cyc; k < NCYC; k++) begin
            exp_stall[k] = 0; exp_br[k] = 0; exp_en[k] = 0; exp_addr[k] = '0; exp_data[k] = '0;
            lit_wb_on[k] = 0; lit_br_on[k] = 0; lit_st_on[k] = 0;
        end
        if (check_async) begin
            #1;
            check_output("async_stall", use16 ? 64'(stall16) : 64'(stall32), 64'd0);
            check_output("async_branch", use16 ? 64'(branch16) : 64'(branch32), 64'd0);
            check_output("async_wb_en", use16 ? 64'(wb_en16) : 64'(wb_en32), 64'd0);
            check_output("async_wb_addr", use16 ? 64'(wb_addr16) : 64'(wb_addr32), 64'd0);
            check_output("async_wb_data", use16 ? 64'(wb_data16) : 64'(wb_data32), 64'd0);
        end
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of the active instance against the model and the literal table
    always @(negedge clk) begin
        if (checking && cyc < NCYC) begin
            act_stall = use16 ? stall16 : stall32;
            act_br    = use16 ? branch16 : branch32;
            act_en    = use16 ? wb_en16 : wb_en32;
            act_addr  = use16 ? 8'(wb_addr16) : 8'(wb_addr32);
            act_data  = use16 ? 64'(wb_data16) : 64'(wb_data32);
            check_output("stall", 64'(act_stall), 64'(exp_stall[cyc]));
            check_output("branch", 64'(act_br), 64'(exp_br[cyc]));
            check_output("wb_en", 64'(act_en), 64'(exp_en[cyc]));
            if (exp_en[cyc]) begin
                check_output("wb_addr", 64'(act_addr), 64'(exp_addr[cyc]));
                check_output("wb_data", act_data, exp_data[cyc]);
            end
            if (lit_wb_on[cyc]) begin
                check_output("lit_wb_en", 64'(act_en), 64'(lit_wb_en[cyc]));
                if (lit_wb_en[cyc]) begin
                    check_output("lit_wb_addr", 64'(act_addr), 64'(lit_addr[cyc]));
                    check_output("lit_wb_data", act_data, lit_data[cyc]);
                end
            end
            if (lit_br_on[cyc])
                check_output("lit_branch", 64'(act_br), 64'(lit_br[cyc]));
            if (lit_st_on[cyc])
                check_output("lit_stall", 64'(act_stall), 64'(lit_st[cyc]));
        end
    end

    initial begin
        int a;
        int b;
        for (int k = 0; k < 256; k++)
            mmem[k] = 64'd0;
        rst_n = 1'b1;
        instr_valid = 1'b0;
        instr = 32'h0;
        wb_id = 2'b00;
        me_id = 3'b000;
        ex_id = 4'b0000;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        checking = 1;
        reset_pipeline(2, 1'b1);

        // 32-bit instance: forwarding, load-use stall, ALU functions
        addi(1, 0, 16'd5, a);            lit_wb(a + 3, 1, 1, 64'd5);
        alu_r(1, 1, 2, 6'h20, a);        lit_wb(a + 3, 1, 2, 64'd10);
        sw(2, 0, 16'd3, a);
        lw(3, 0, 16'd3, a);              lit_wb(a + 3, 1, 3, 64'd10);
        alu_r(3, 3, 4, 6'h20, a);        lit_wb(a + 3, 1, 4, 64'd20);
        lit_stall(a - 1, 1);             lit_stall(a, 0);
        lit_wb(a + 2, 0, 0, 64'd0);
        addi(6, 0, 16'hFFFF, a);         lit_wb(a + 3, 1, 6, 64'hFFFF_FFFF);
        addi(7, 0, 16'd1, a);
        alu_r(6, 7, 5, 6'h2A, a);        lit_wb(a + 3, 1, 5, 64'd1);
        alu_r(7, 6, 8, 6'h2A, a);        lit_wb(a + 3, 1, 8, 64'd0);
        sub_r(0, 7, 9, a);               lit_wb(a + 3, 1, 9, 64'hFFFF_FFFF);
        alu_r(1, 1, 0, 6'h20, a);        lit_wb(a + 3, 0, 0, 64'd0);
        alu_r(0, 0, 15, 6'h20, a);       lit_wb(a + 3, 1, 15, 64'd0);
        alu_r(2, 4, 10, 6'h24, a);       lit_wb(a + 3, 1, 10, 64'd0);
        alu_r(2, 4, 11, 6'h25, a);       lit_wb(a + 3, 1, 11, 64'd30);
        alu_r(1, 2, 12, 6'h00, a);       lit_wb(a + 3, 1, 12, 64'd15);
        alu_r(2, 1, 13, 6'h22, a);       lit_wb(a + 3, 1, 13, 64'd5);
        apply_stimulus(1'b1, r_type(1, 2, 17, 6'h22), 2'b10, 3'b000, 4'b1110, a);
        lit_wb(a + 3, 1, 17, 64'd15);
        addi(14, 0, 16'd7, a);
        bubble(2);
        alu_r(14, 0, 16, 6'h20, b);      lit_wb(b + 3, 1, 16, 64'd7);
        beq(1, 1, a);                    lit_branch(a + 1, 0); lit_branch(a + 2, 1); lit_branch(a + 3, 0);
        beq(1, 2, a);                    lit_branch(a + 2, 0);
        bubble(4);

        // reset with three instructions in flight
        addi(1, 0, 16'd9, a);
        addi(2, 0, 16'd8, a);
        addi(3, 0, 16'd7, a);
        reset_pipeline(2, 1'b1);
        bubble(4);
        alu_r(1, 2, 4, 6'h20, a);        lit_wb(a + 3, 1, 4, 64'd0);
        alu_r(3, 0, 5, 6'h20, a);        lit_wb(a + 3, 1, 5, 64'd0);
        bubble(4);

        // 16-bit instance with 8 registers and 16 memory words
        use16 = 1;
        dw = 16;
        ra = 3;
        mdepth = 16;
        reset_pipeline(2, 1'b1);
        addi(1, 0, 16'd17, a);           lit_wb(a + 3, 1, 1, 64'd17);
        addi(2, 0, 16'h1234, a);         lit_wb(a + 3, 1, 2, 64'h1234);
        sw(2, 1, 16'd0, a);
        lw(3, 0, 16'd1, a);              lit_wb(a + 3, 1, 3, 64'h1234);
        sub_r(0, 1, 4, a);               lit_wb(a + 3, 1, 4, 64'hFFEF);
        addi(5, 0, 16'h8000, a);         lit_wb(a + 3, 1, 5, 64'h8000);
        alu_r(5, 1, 6, 6'h2A, a);        lit_wb(a + 3, 1, 6, 64'd1);
        lw(7, 1, 16'd16, a);             lit_wb(a + 3, 1, 7, 64'h1234);
        bubble(4);
        addi(1, 0, 16'd3, a);
        addi(2, 0, 16'd4, a);
        addi(3, 0, 16'd5, a);
        reset_pipeline(2, 1'b1);
        bubble(4);
        alu_r(1, 2, 4, 6'h20, a);        lit_wb(a + 3, 1, 4, 64'd0);
        bubble(4);

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
